// File: rtl/alu_station_pkg.sv
// alu_station_pkg: shared types, tag constants, ALU op codes, the FSM state
// type and the write-back snoop helper for the ALU reservation station.
package alu_station_pkg;

  localparam int XLEN   = 32;
  localparam int NUM_WB = 4;   // write-back buses; bus k carries tag k+1

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;
  typedef logic [2:0]      regtag_t;
  typedef logic [4:0]      regaddr_t;

  // Fixed tag encoding shared with the allocator and register file
  localparam regtag_t UNLOCKED   = 3'd0;
  localparam regtag_t ALU_MASTER = 3'd1;
  localparam regtag_t ALU_SALVER = 3'd2;
  localparam regtag_t LOAD_STORE = 3'd3;
  localparam regtag_t ALU_MISAKA = 3'd4;
  localparam regtag_t BRANCH_SEL = 3'd5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_LUI   = 4'd10,
    OP_AUIPC = 4'd11,
    OP_LINK  = 4'd12
  } alu_op_e;

  // Held station entry (destination tag is implicit: it is OWN_TAG)
  typedef struct packed {
    addr_t      pc;
    logic [3:0] op;
    regtag_t    tagx;
    regtag_t    tagy;
    word_t      datax;
    word_t      datay;
    regaddr_t   addrw;
  } sinst_t;

  typedef struct packed {
    regtag_t tag;
    word_t   data;
  } opnd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_DONE} st_e;

  // Resolve one operand against all write-back buses. Matching uses the
  // incoming tag, so a cleared tag (0) never matches again.
  function automatic opnd_t snoop(opnd_t o, logic [NUM_WB-1:0] en,
                                  logic [NUM_WB-1:0][XLEN-1:0] wd);
    opnd_t r;
    r = o;
    for (int k = 0; k < NUM_WB; k++) begin
      if (en[k] && (o.tag == regtag_t'(k + 1))) begin
        r.tag  = UNLOCKED;
        r.data = wd[k];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_station_if.sv
// alu_station_if: dispatch issue port, the four write-back snoop buses and
// the station's own result broadcast.
//   slave  : the station (consumes issue/snoop, drives busy and broadcast)
//   master : allocator / environment side
interface alu_station_if;
  import alu_station_pkg::*;

  logic     en_in;
  addr_t    pc_in;
  logic [3:0] op_in;
  regtag_t  tagx_in, tagy_in;
  word_t    datax_in, datay_in;
  regtag_t  tagw_in;
  regaddr_t addrw_in;
  logic     en_mw0, en_mw1, en_mw2, en_mw3;
  word_t    write_data0, write_data1, write_data2, write_data3;
  logic     wb_stall_in;
  logic     busy_out;
  logic     en_mw_out;
  regaddr_t reg_write_addr_out;
  word_t    write_data_out;

  modport slave (
    input  en_in, pc_in, op_in, tagx_in, tagy_in, datax_in, datay_in,
           tagw_in, addrw_in, en_mw0, en_mw1, en_mw2, en_mw3,
           write_data0, write_data1, write_data2, write_data3, wb_stall_in,
    output busy_out, en_mw_out, reg_write_addr_out, write_data_out
  );

  modport master (
    output en_in, pc_in, op_in, tagx_in, tagy_in, datax_in, datay_in,
           tagw_in, addrw_in, en_mw0, en_mw1, en_mw2, en_mw3,
           write_data0, write_data1, write_data2, write_data3, wb_stall_in,
    input  busy_out, en_mw_out, reg_write_addr_out, write_data_out
  );
endinterface

// File: rtl/alu_station_core.sv
// alu_core: purely combinational ALU.
//   op_i  : sub-op (codes 13..15 give 0)
//   pc_i  : instruction pc (AUIPC / LINK)
//   x_i/y_i : operands; shifts use y_i[4:0]
//   res_o : 32-bit modulo result
module alu_core
  import alu_station_pkg::*;
(
  input  logic [3:0] op_i,
  input  addr_t      pc_i,
  input  word_t      x_i,
  input  word_t      y_i,
  output word_t      res_o
);
  logic [4:0] sh;
  assign sh = y_i[4:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:   res_o = x_i + y_i;
      OP_SUB:   res_o = x_i - y_i;
      OP_SLL:   res_o = x_i << sh;
      OP_SLT:   res_o = {31'd0, ($signed(x_i) < $signed(y_i))};
      OP_SLTU:  res_o = {31'd0, (x_i < y_i)};
      OP_XOR:   res_o = x_i ^ y_i;
      OP_SRL:   res_o = x_i >> sh;
      OP_SRA:   res_o = word_t'($signed(x_i) >>> sh);
      OP_OR:    res_o = x_i | y_i;
      OP_AND:   res_o = x_i & y_i;
      OP_LUI:   res_o = y_i;
      OP_AUIPC: res_o = pc_i + y_i;
      OP_LINK:  res_o = pc_i + 32'd4;
      default:  res_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_station.sv
// alu_station: single-entry reservation station + execute stage for one ALU
// slot. Accepts an issued op while idle, snoops the four write-back buses
// until both operands are unlocked, executes, and broadcasts the result on
// its own write-back bus (held while wb_stall_in is high).
//   clk, rst (async, active low)
//   io : alu_station_if.slave (issue port, snoop buses, result broadcast)
//   OWN_TAG : tag owned by this instance (1/2/4)
// Optional: `define ALU_EARLY_RELEASE_EN lets a new op issue in the same cycle
// the broadcast completes (busy_out drops combinationally in DONE).
module alu_station
  import alu_station_pkg::*;
#(
  parameter regtag_t OWN_TAG = ALU_MASTER
) (
  input  logic clk,
  input  logic rst,
  alu_station_if.slave io
);

  st_e      st_q, st_d;
  sinst_t   ent_q, ent_d;
  word_t    wdata_q, wdata_d;
  regaddr_t waddr_q, waddr_d;

  logic  busy, accept, own_rel;
  word_t res;
  opnd_t ix, iy, wx, wy;

  logic [NUM_WB-1:0]           wb_en, snp_en;
  logic [NUM_WB-1:0][XLEN-1:0] wb_data, snp_data;

  assign wb_en   = {io.en_mw3, io.en_mw2, io.en_mw1, io.en_mw0};
  assign wb_data = {io.write_data3, io.write_data2, io.write_data1, io.write_data0};

  // Broadcast completes this cycle
  assign own_rel = (st_q == S_DONE) && !io.wb_stall_in;

`ifdef ALU_EARLY_RELEASE_EN
  assign busy = (st_q != S_IDLE) && !own_rel;
`else
  assign busy = (st_q != S_IDLE);
`endif

  assign accept = io.en_in && !busy;

  // Snoop view of the buses; with early release, a same-cycle issue must
  // also see our own completing broadcast on our own bus.
  always_comb begin
    snp_en   = wb_en;
    snp_data = wb_data;
`ifdef ALU_EARLY_RELEASE_EN
    for (int k = 0; k < NUM_WB; k++) begin
      if (own_rel && (OWN_TAG == regtag_t'(k + 1))) begin
        snp_en[k]   = 1'b1;
        snp_data[k] = wdata_q;
      end
    end
`endif
  end

  always_comb begin
    ix = snoop({io.tagx_in, io.datax_in}, snp_en, snp_data);
    iy = snoop({io.tagy_in, io.datay_in}, snp_en, snp_data);
    wx = snoop({ent_q.tagx, ent_q.datax}, snp_en, snp_data);
    wy = snoop({ent_q.tagy, ent_q.datay}, snp_en, snp_data);
  end

  alu_core u_core (
    .op_i  (ent_q.op),
    .pc_i  (ent_q.pc),
    .x_i   (ent_q.datax),
    .y_i   (ent_q.datay),
    .res_o (res)
  );

  always_comb begin
    st_d    = st_q;
    ent_d   = ent_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    case (st_q)
      S_IDLE: ;
      S_WAIT: begin
        ent_d.tagx  = wx.tag;
        ent_d.datax = wx.data;
        ent_d.tagy  = wy.tag;
        ent_d.datay = wy.data;
        if (wx.tag == UNLOCKED && wy.tag == UNLOCKED) st_d = S_EXEC;
      end
      S_EXEC: begin
        wdata_d = res;
        waddr_d = ent_q.addrw;
        st_d    = S_DONE;
      end
      S_DONE: if (!io.wb_stall_in) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    // Issue capture overrides: only reachable from IDLE, or from a
    // completing DONE when early release is built in.
    if (accept) begin
      ent_d.pc    = io.pc_in;
      ent_d.op    = io.op_in;
      ent_d.addrw = io.addrw_in;
      ent_d.tagx  = ix.tag;
      ent_d.datax = ix.data;
      ent_d.tagy  = iy.tag;
      ent_d.datay = iy.data;
      st_d = (ix.tag == UNLOCKED && iy.tag == UNLOCKED) ? S_EXEC : S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= S_IDLE;
      ent_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      st_q    <= st_d;
      ent_q   <= ent_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  assign io.busy_out           = busy;
  assign io.en_mw_out          = (st_q == S_DONE);
  assign io.reg_write_addr_out = waddr_q;
  assign io.write_data_out     = wdata_q;

`ifndef SYNTHESIS
  // Allocator protocol checks: issue while busy is dropped; tags 5..7 never
  // appear on a bus and would park the station in WAIT forever.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(io.en_in && busy))
        else $warning("alu_station: issue strobe while busy dropped");
      assert (!(accept && (io.tagx_in > ALU_MISAKA || io.tagy_in > ALU_MISAKA)))
        else $warning("alu_station: operand tag with no write-back bus");
      assert (!(accept && io.tagw_in != OWN_TAG))
        else $warning("alu_station: destination tag differs from own tag");
    end
  end
`endif

endmodule

// File: tb/tb_alu_station.sv
module tb_alu_station;
  import alu_station_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_station_if io();

  alu_station #(.OWN_TAG(ALU_MASTER)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int errs = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change 2ns after the edge, strobes self-clear
  task automatic cyc();
    @(posedge clk);
    #2;
    io.en_in  = 1'b0;
    io.en_mw0 = 1'b0;
    io.en_mw1 = 1'b0;
    io.en_mw2 = 1'b0;
    io.en_mw3 = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input word_t pc, input regtag_t tx,
                       input regtag_t ty, input word_t dx, input word_t dy,
                       input regaddr_t aw);
    io.en_in    = 1'b1;
    io.op_in    = op;
    io.pc_in    = pc;
    io.tagx_in  = tx;
    io.tagy_in  = ty;
    io.datax_in = dx;
    io.datay_in = dy;
    io.tagw_in  = ALU_MASTER;
    io.addrw_in = aw;
  endtask

  // Ready-operand op: EXEC at T+1, DONE at T+2, idle at T+3
  task automatic run_ready(input string tag, input logic [3:0] op, input word_t pc,
                           input word_t x, input word_t y, input regaddr_t aw,
                           input word_t exp);
    cyc(); issue(op, pc, UNLOCKED, UNLOCKED, x, y, aw);
    cyc(); #1; chk({tag, ".en_t1"}, {31'd0, io.en_mw_out}, 32'd0);
    cyc(); #1;
    chk({tag, ".en"},   {31'd0, io.en_mw_out}, 32'd1);
    chk({tag, ".data"}, io.write_data_out, exp);
    chk({tag, ".addr"}, {27'd0, io.reg_write_addr_out}, {27'd0, aw});
    cyc(); #1; chk({tag, ".idle"}, {31'd0, io.busy_out}, 32'd0);
  endtask

  initial begin
    io.en_in = 0; io.pc_in = 0; io.op_in = 0; io.tagx_in = 0; io.tagy_in = 0;
    io.datax_in = 0; io.datay_in = 0; io.tagw_in = ALU_MASTER; io.addrw_in = 0;
    io.en_mw0 = 0; io.en_mw1 = 0; io.en_mw2 = 0; io.en_mw3 = 0;
    io.write_data0 = 0; io.write_data1 = 0; io.write_data2 = 0; io.write_data3 = 0;
    io.wb_stall_in = 0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst.busy", {31'd0, io.busy_out}, 32'd0);
    chk("rst.en",   {31'd0, io.en_mw_out}, 32'd0);
    chk("rst.data", io.write_data_out, 32'd0);
    chk("rst.addr", {27'd0, io.reg_write_addr_out}, 32'd0);
    cyc(); cyc();
    rst = 1'b1;

    // ADD 5+7 with ready operands, plus busy timing
    cyc(); issue(OP_ADD, 32'h0, UNLOCKED, UNLOCKED, 32'd5, 32'd7, 5'd3);
    #1; chk("add.busy_t0", {31'd0, io.busy_out}, 32'd0);
    cyc(); #1; chk("add.busy_t1", {31'd0, io.busy_out}, 32'd1);
    chk("add.en_t1", {31'd0, io.en_mw_out}, 32'd0);
    cyc(); #1; chk("add.en_t2", {31'd0, io.en_mw_out}, 32'd1);
    chk("add.data", io.write_data_out, 32'd12);
    chk("add.addr", {27'd0, io.reg_write_addr_out}, 32'd3);
    cyc(); #1; chk("add.busy_t3", {31'd0, io.busy_out}, 32'd0);
    chk("add.en_t3", {31'd0, io.en_mw_out}, 32'd0);
    chk("add.hold", io.write_data_out, 32'd12);

    // SUB waiting on LOAD_STORE bus (bus 2) at T+4
    cyc(); issue(OP_SUB, 32'h0, LOAD_STORE, UNLOCKED, 32'hDEAD, 32'd1, 5'd5);
    cyc(); cyc(); cyc(); #1;
    chk("sub.busy_wait", {31'd0, io.busy_out}, 32'd1);
    chk("sub.en_wait",   {31'd0, io.en_mw_out}, 32'd0);
    cyc(); io.en_mw2 = 1'b1; io.write_data2 = 32'd10;
    cyc(); #1; chk("sub.en_t5", {31'd0, io.en_mw_out}, 32'd0);
    cyc(); #1; chk("sub.en_t6", {31'd0, io.en_mw_out}, 32'd1);
    chk("sub.data", io.write_data_out, 32'd9);
    chk("sub.addr", {27'd0, io.reg_write_addr_out}, 32'd5);
    cyc();

    // SLL, both operands from buses 0 and 3 in the same cycle
    cyc(); issue(OP_SLL, 32'h0, ALU_MASTER, ALU_MISAKA, 32'd0, 32'd0, 5'd7);
    cyc(); io.en_mw0 = 1'b1; io.write_data0 = 32'd2;
    io.en_mw3 = 1'b1; io.write_data3 = 32'd3;
    cyc(); #1; chk("sll.en_c1", {31'd0, io.en_mw_out}, 32'd0);
    cyc(); #1; chk("sll.en_c2", {31'd0, io.en_mw_out}, 32'd1);
    chk("sll.data", io.write_data_out, 32'd16);
    chk("sll.addr", {27'd0, io.reg_write_addr_out}, 32'd7);
    cyc();

    // SLTU with y resolved by same-cycle snoop of bus 1 at issue
    cyc(); issue(OP_SLTU, 32'h0, UNLOCKED, ALU_SALVER, 32'd0, 32'h5, 5'd8);
    io.en_mw1 = 1'b1; io.write_data1 = 32'h8000_0000;
    cyc(); #1; chk("sltu.busy_t1", {31'd0, io.busy_out}, 32'd1);
    chk("sltu.en_t1", {31'd0, io.en_mw_out}, 32'd0);
    cyc(); #1; chk("sltu.en_t2", {31'd0, io.en_mw_out}, 32'd1);
    chk("sltu.data", io.write_data_out, 32'd1);
    cyc();

    // Op coverage and modulo / boundary cases
    run_ready("sra",   OP_SRA,   32'h0,    32'h8000_0010, 32'd4,  5'd1, 32'hF800_0001);
    run_ready("srl",   OP_SRL,   32'h0,    32'h8000_0010, 32'd4,  5'd2, 32'h0800_0001);
    run_ready("slt",   OP_SLT,   32'h0,    32'hFFFF_FFFF, 32'd1,  5'd3, 32'd1);
    run_ready("subw",  OP_SUB,   32'h0,    32'd0,         32'd1,  5'd4, 32'hFFFF_FFFF);
    run_ready("addw",  OP_ADD,   32'h0,    32'hFFFF_FFFF, 32'd2,  5'd6, 32'd1);
    run_ready("sll33", OP_SLL,   32'h0,    32'd1,         32'd33, 5'd9, 32'd2);
    run_ready("lui",   OP_LUI,   32'h0,    32'd9,   32'h1234_5000, 5'd10, 32'h1234_5000);
    run_ready("auipc", OP_AUIPC, 32'h1000, 32'd9,         32'h20, 5'd11, 32'h0000_1020);
    run_ready("link",  OP_LINK,  32'h1000, 32'd9,         32'h20, 5'd12, 32'h0000_1004);
    run_ready("or",    OP_OR,    32'h0,    32'hF0,        32'h0F, 5'd13, 32'hFF);
    run_ready("and",   OP_AND,   32'h0,    32'hF0,        32'h3C, 5'd14, 32'h30);
    run_ready("op13",  4'd13,    32'h0,    32'hF0,        32'h3C, 5'd15, 32'd0);
    run_ready("a0",    OP_XOR,   32'h0,    32'h1,         32'h3,  5'd0,  32'h2);

    // Write-back stall: DONE held for 3 stalled cycles + completing cycle
    cyc(); issue(OP_XOR, 32'h0, UNLOCKED, UNLOCKED, 32'hF0F0, 32'h0FF0, 5'd9);
    cyc();
    cyc(); io.wb_stall_in = 1'b1; #1;
    chk("stl.en0", {31'd0, io.en_mw_out}, 32'd1);
    chk("stl.d0",  io.write_data_out, 32'h0000_FF00);
    cyc(); issue(OP_ADD, 32'h0, UNLOCKED, UNLOCKED, 32'd1, 32'd1, 5'd2); #1;
    chk("stl.en1", {31'd0, io.en_mw_out}, 32'd1);
    chk("stl.d1",  io.write_data_out, 32'h0000_FF00);
    cyc(); #1;
    chk("stl.en2", {31'd0, io.en_mw_out}, 32'd1);
    chk("stl.a2",  {27'd0, io.reg_write_addr_out}, 32'd9);
    cyc(); io.wb_stall_in = 1'b0; #1;
    chk("stl.en3", {31'd0, io.en_mw_out}, 32'd1);
    chk("stl.d3",  io.write_data_out, 32'h0000_FF00);
    cyc(); #1;
    chk("stl.en4",  {31'd0, io.en_mw_out}, 32'd0);
    chk("stl.idle", {31'd0, io.busy_out}, 32'd0);
    cyc(); cyc(); #1;
    chk("stl.drop", {31'd0, io.en_mw_out}, 32'd0);
    chk("stl.dk",   io.write_data_out, 32'h0000_FF00);

    // Reset while waiting: entry discarded, later bus match ignored
    cyc(); issue(OP_ADD, 32'h0, LOAD_STORE, UNLOCKED, 32'd0, 32'd1, 5'd4);
    cyc(); cyc();
    rst = 1'b0; #1;
    chk("rw.busy", {31'd0, io.busy_out}, 32'd0);
    chk("rw.en",   {31'd0, io.en_mw_out}, 32'd0);
    chk("rw.data", io.write_data_out, 32'd0);
    cyc(); rst = 1'b1;
    cyc(); io.en_mw2 = 1'b1; io.write_data2 = 32'd5;
    cyc(); cyc(); #1;
    chk("rw.nobc", {31'd0, io.en_mw_out}, 32'd0);
    chk("rw.idle", {31'd0, io.busy_out}, 32'd0);

`ifdef ALU_EARLY_RELEASE_EN
    // Back-to-back issue: broadcasts 2 cycles apart
    cyc(); issue(OP_ADD, 32'h0, UNLOCKED, UNLOCKED, 32'd1, 32'd1, 5'd1);
    cyc();
    cyc(); #1;
    chk("er.en0",   {31'd0, io.en_mw_out}, 32'd1);
    chk("er.d0",    io.write_data_out, 32'd2);
    chk("er.busy0", {31'd0, io.busy_out}, 32'd0);
    issue(OP_ADD, 32'h0, ALU_MASTER, UNLOCKED, 32'd0, 32'd3, 5'd2);
    cyc(); #1; chk("er.en1", {31'd0, io.en_mw_out}, 32'd0);
    cyc(); #1;
    chk("er.en2", {31'd0, io.en_mw_out}, 32'd1);
    chk("er.d2",  io.write_data_out, 32'd5);
    cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
